rv32_instr_encoder: RTL and testbench

//  Inverse of the ID-stage decoder: turns (ALU op, operand form, rd/rs1/rs2, imm) requests into
//  32-bit RV32I words (R-type 0110011, I-type 0010011, LUI 0110111) and streams them into

---
 rtl/rv32_instr_encoder_pkg.sv | 45 ++++
 rtl/rv32_instr_encoder_if.sv | 32 +++
 rtl/rv32_instr_encoder_instr_fifo.sv | 48 ++++
 rtl/rv32_instr_encoder.sv | 164 ++++++++++++++++
 tb/tb_rv32_instr_encoder.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_instr_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder.
//   - RV32I opcodes, funct3/funct7 field values and the canonical NOP word
//   - ALU control codes, numerically identical to the ID-stage decoder's
//   - writer FSM state type
package rv32_instr_encoder_pkg;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;   // SUB / SRA

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;  // addi x0,x0,0

    // ALU control codes shared with the decoder; 11..15 are not encodable
    localparam logic [3:0] ALU_SLL  = 4'd0;
    localparam logic [3:0] ALU_SRL  = 4'd1;
    localparam logic [3:0] ALU_SRA  = 4'd2;
    localparam logic [3:0] ALU_ADD  = 4'd3;
    localparam logic [3:0] ALU_SUB  = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_AND  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rv32_instr_encoder_if.sv
// Request + instruction-memory write bus of the encoder.
//   master : request source / memory side (drives req_*, mem_ready)
//   slave  : the encoder (drives req_ready, mem_we/addr/wdata)
interface rv32_instr_encoder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_alu_ctrl;
    logic              req_imm_sel;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              req_last;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;

    modport master (
        output req_valid, req_alu_ctrl, req_imm_sel, req_rd, req_rs1, req_rs2,
               req_imm, req_last, mem_ready,
        input  req_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_alu_ctrl, req_imm_sel, req_rd, req_rs1, req_rs2,
               req_imm, req_last, mem_ready,
        output req_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv32_instr_encoder_instr_fifo.sv
// instr_fifo: synchronous FIFO, registered storage, no fall-through.
//   push/din  : write when not full (or when popping in the same cycle)
//   pop/dout  : dout is the head entry; pop ignored when empty
//   full/empty: status flags
// Reset: synchronous, active low (rst_n).
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty;
    // When full, the slot being freed this cycle is the one written.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/rv32_instr_encoder.sv
// rv32_instr_encoder: turns ALU-op requests into RV32I words (R-type, I-type,
// LUI) and writes them to instruction memory at consecutive word addresses.
//   clk, rst_n        : clock, synchronous active-low reset
//   start, base_addr  : begin a sequence at base_addr (low 2 bits dropped)
//   bus (slave)       : request handshake + memory write port
//   busy, done        : FSM in RUN/DRAIN, FSM in DONE
//   count             : words written since start (saturating)
//   err               : sticky illegal-request flag, cleared by start
// Optional build macro IMM_RANGE_CHECK_EN: out-of-range immediates become
// NOP + err instead of being truncated.
module rv32_instr_encoder
    import rv32_instr_encoder_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    count,
    output logic                err,
    rv32_instr_encoder_if.slave bus
);
    state_e            state, state_nxt;
    logic              enc_vld;
    logic [31:0]       enc_word;
    logic              fifo_full, fifo_empty;
    logic              push, pop, accept, start_ok;
    logic [31:0]       head;
    logic [ADDR_W-1:0] addr;

    logic [3:0]  alu;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        is_shift, is_lui, bad;
    logic [31:0] word;

    assign alu = bus.req_alu_ctrl;
    assign imm = bus.req_imm;

    // Encoder: pick funct fields, then assemble the format.
    always_comb begin
        f3       = F3_ADD;
        f7       = F7_BASE;
        bad      = 1'b0;
        is_shift = 1'b0;
        is_lui   = 1'b0;
        word     = NOP_WORD;
        case (alu)
            ALU_ADD:  f3 = F3_ADD;
            ALU_SUB:  begin f7 = F7_ALT; bad = bus.req_imm_sel; end  // no SUBI in RV32I
            ALU_SLL:  begin f3 = F3_SLL; is_shift = 1'b1; end
            ALU_SRL:  begin f3 = F3_SR;  is_shift = 1'b1; end
            ALU_SRA:  begin f3 = F3_SR;  f7 = F7_ALT; is_shift = 1'b1; end
            ALU_SLT:  f3 = F3_SLT;
            ALU_SLTU: f3 = F3_SLTU;
            ALU_XOR:  f3 = F3_XOR;
            ALU_OR:   f3 = F3_OR;
            ALU_AND:  f3 = F3_AND;
            ALU_LUI:  is_lui = 1'b1;
            default:  bad = 1'b1;
        endcase
        if (is_lui)
            word = {imm[31:12], bus.req_rd, OPC_LUI};
        else if (!bus.req_imm_sel)
            word = {f7, bus.req_rs2, bus.req_rs1, f3, bus.req_rd, OPC_R};
        else if (is_shift)
            word = {f7, imm[4:0], bus.req_rs1, f3, bus.req_rd, OPC_I};
        else
            word = {imm[11:0], bus.req_rs1, f3, bus.req_rd, OPC_I};
`ifdef IMM_RANGE_CHECK_EN
        if (is_lui)
            bad = bad | (imm[11:0] != 12'd0);
        else if (bus.req_imm_sel && is_shift)
            bad = bad | (imm[31:5] != 27'd0);
        else if (bus.req_imm_sel)
            bad = bad | !((imm[31:11] == '0) || (imm[31:11] == '1));
`endif
        if (bad) word = NOP_WORD;
    end

    // Writer side: head of FIFO is presented until memory takes it.
    assign pop           = !fifo_empty && bus.mem_ready;
    assign push          = enc_vld && (!fifo_full || pop);
    assign bus.req_ready = (state == ST_RUN) && (!enc_vld || push);
    assign accept        = bus.req_valid && bus.req_ready;
    assign start_ok      = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign bus.mem_we    = fifo_empty ? 4'h0 : 4'hF;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = fifo_empty ? 32'd0 : head;

    instr_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (enc_word),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (accept && bus.req_last) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!enc_vld && fifo_empty) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = ST_RUN;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            enc_vld  <= 1'b0;
            enc_word <= '0;
            addr     <= '0;
            count    <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                enc_vld  <= 1'b1;
                enc_word <= word;
                if (bad) err <= 1'b1;
            end else if (push) begin
                enc_vld <= 1'b0;
            end
            // start_ok and accept/pop are mutually exclusive by state
            if (start_ok) begin
                addr  <= base_addr & ~ADDR_W'(3);
                count <= '0;
                err   <= 1'b0;
            end else if (pop) begin
                addr <= addr + ADDR_W'(4);
                if (count != '1) count <= count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rv32_instr_encoder.sv
module tb_rv32_instr_encoder;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [3:0]  alu;
        logic        sel;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
    } req_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [31:0] base_addr = '0;
    logic busy, done, err;
    logic [CNT_W-1:0] count;

    rv32_instr_encoder_if #(.ADDR_W(32)) bus ();

    rv32_instr_encoder #(.FIFO_DEPTH(4), .ADDR_W(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .count(count), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];
    req_t cur[$];

    // memory model: record every completed write
    always @(negedge clk) begin
        if (bus.mem_we != 4'h0 && bus.mem_ready) begin
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference encoder built from field positions with plain arithmetic.
    task automatic ref_enc(input req_t r, output logic [31:0] w, output bit b);
        int f3; bit alt, shift, lui;
        logic [31:0] rd, rs1, rs2;
        f3 = 0; alt = 0; shift = 0; lui = 0; b = 0;
        rd = 32'(r.rd); rs1 = 32'(r.rs1); rs2 = 32'(r.rs2);
        case (int'(r.alu))
            0: begin f3 = 1; shift = 1; end
            1: begin f3 = 5; shift = 1; end
            2: begin f3 = 5; shift = 1; alt = 1; end
            3: f3 = 0;
            4: begin f3 = 0; alt = 1; b = r.sel; end
            5: f3 = 4;
            6: f3 = 6;
            7: f3 = 7;
            8: f3 = 2;
            9: f3 = 3;
            10: lui = 1;
            default: b = 1;
        endcase
        if (lui)
            w = (r.imm & 32'hFFFF_F000) | (rd << 7) | 32'h37;
        else if (!r.sel)
            w = (32'(alt) << 30) | (rs2 << 20) | (rs1 << 15) | (32'(f3) << 12) | (rd << 7) | 32'h33;
        else if (shift)
            w = (32'(alt) << 30) | ((r.imm & 32'd31) << 20) | (rs1 << 15) | (32'(f3) << 12) | (rd << 7) | 32'h13;
        else
            w = ((r.imm & 32'hFFF) << 20) | (rs1 << 15) | (32'(f3) << 12) | (rd << 7) | 32'h13;
`ifdef IMM_RANGE_CHECK_EN
        if (lui) b = b | ((r.imm & 32'hFFF) != 0);
        else if (r.sel && shift) b = b | (r.imm > 32'd31);
        else if (r.sel) b = b | ($signed(r.imm) < -2048) | ($signed(r.imm) > 2047);
`endif
        if (b) w = 32'h13;
    endtask

    function automatic req_t mk(input int alu, input bit sel, input int rd, input int rs1,
                                input int rs2, input logic [31:0] imm);
        req_t r;
        r.alu = 4'(alu); r.sel = sel; r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
        return r;
    endfunction

    function automatic req_t rnd_req();
        return mk($urandom_range(0, 15), 1'($urandom), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom);
    endfunction

    task automatic pulse_start(input logic [31:0] base);
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input req_t r, input bit last, input int tmo, input bit rnd, output bit ok);
        bus.req_valid = 1'b1; bus.req_alu_ctrl = r.alu; bus.req_imm_sel = r.sel;
        bus.req_rd = r.rd; bus.req_rs1 = r.rs1; bus.req_rs2 = r.rs2;
        bus.req_imm = r.imm; bus.req_last = last;
        ok = 1'b0;
        for (int i = 0; i < tmo && !ok; i++) begin
            @(negedge clk);
            if (bus.req_ready) ok = 1'b1;
            @(posedge clk); #1;
            if (rnd) bus.mem_ready = ($urandom_range(0, 3) != 0);
        end
        bus.req_valid = 1'b0; bus.req_last = 1'b0;
    endtask

    task automatic wait_done(input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
                if (rnd) bus.mem_ready = ($urandom_range(0, 3) != 0);
            end
        end
        chk("done_reached", 64'(seen), 64'd1);
        bus.mem_ready = 1'b1;
    endtask

    task automatic check_writes(input logic [31:0] base);
        logic [31:0] w, ea;
        bit b, any_bad;
        int n;
        any_bad = 1'b0;
        n = cur.size();
        chk("n_writes", 64'(wr_a.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            ref_enc(cur[i], w, b);
            any_bad = any_bad | b;
            ea = (base & 32'hFFFF_FFFC) + 32'(4 * i);
            if (i < wr_a.size()) begin
                chk("wr_addr", 64'(wr_a[i]), 64'(ea));
                chk("wr_word", 64'(wr_d[i]), 64'(w));
            end
        end
        chk("count", 64'(count), 64'((n > CMAX) ? CMAX : n));
        chk("err", 64'(err), 64'(any_bad));
        chk("busy_end", 64'(busy), 64'd0);
    endtask

    task automatic run_seq(input logic [31:0] base, input bit rnd);
        bit ok;
        wr_a.delete(); wr_d.delete();
        pulse_start(base);
        foreach (cur[i]) begin
            send(cur[i], i == cur.size() - 1, 100, rnd, ok);
            chk("req_accepted", 64'(ok), 64'd1);
        end
        wait_done(rnd);
        check_writes(base);
    endtask

    initial begin
        bit ok;
        logic [31:0] h_addr, h_data;
        bus.req_valid = 0; bus.req_alu_ctrl = 0; bus.req_imm_sel = 0; bus.req_rd = 0;
        bus.req_rs1 = 0; bus.req_rs2 = 0; bus.req_imm = 0; bus.req_last = 0; bus.mem_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_we", 64'(bus.mem_we), 64'd0);
        chk("rst_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_flags", 64'({busy, done, err}), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        @(posedge clk); #1;

        // 1: single ADD with latency check
        cur = '{mk(3, 0, 3, 1, 2, 0)};
        wr_a.delete(); wr_d.delete();
        pulse_start(32'h100);
        send(cur[0], 1'b1, 20, 1'b0, ok);
        chk("t1_accept", 64'(ok), 64'd1);
        @(negedge clk);
        chk("t1_we_n1", 64'(bus.mem_we), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_we_n2", 64'(bus.mem_we), 64'hF);
        chk("t1_addr_n2", 64'(bus.mem_addr), 64'h100);
        chk("t1_data_n2", 64'(bus.mem_wdata), 64'h002081B3);
        @(posedge clk); #1;
        wait_done(1'b0);
        check_writes(32'h100);
        chk("t1_done", 64'(done), 64'd1);

        // 2: ADDI with all-ones imm, SRAI
        cur = '{mk(3, 1, 1, 0, 0, 32'hFFFF_FFFF), mk(2, 1, 5, 5, 0, 32'd3)};
        run_seq(32'h200, 1'b0);
        chk("t2_addi", 64'(wr_d[0]), 64'hFFF00093);
        chk("t2_srai", 64'(wr_d[1]), 64'h4032D293);

        // 3: LUI in both operand forms
        cur = '{mk(10, 0, 10, 7, 9, 32'h1234_5000), mk(10, 1, 10, 3, 4, 32'h1234_5000)};
        run_seq(32'h300, 1'b0);
        chk("t3_lui_r", 64'(wr_d[0]), 64'h12345537);
        chk("t3_lui_i", 64'(wr_d[1]), 64'h12345537);

        // 4: SUB immediate is illegal
        cur = '{mk(4, 1, 4, 5, 0, 32'd1)};
        run_seq(32'h340, 1'b0);
        chk("t4_nop", 64'(wr_d[0]), 64'h13);
        chk("t4_err", 64'(err), 64'd1);

        // 5: memory stall, FIFO+encoder fill, ignored start
        cur.delete();
        for (int k = 0; k < 6; k++) cur.push_back(rnd_req());
        wr_a.delete(); wr_d.delete();
        bus.mem_ready = 1'b0;
        pulse_start(32'h400);
        @(negedge clk);
        chk("t5_err_clr", 64'(err), 64'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            send(cur[k], 1'b0, 4, 1'b0, ok);
            chk("t5_accept", 64'(ok), 64'd1);
        end
        send(cur[5], 1'b1, 3, 1'b0, ok);
        chk("t5_sixth_held", 64'(ok), 64'd0);
        @(negedge clk);
        chk("t5_ready_low", 64'(bus.req_ready), 64'd0);
        h_addr = bus.mem_addr; h_data = bus.mem_wdata;
        @(posedge clk); #1;
        pulse_start(32'h0099_9000);
        @(negedge clk);
        chk("t5_addr_hold", 64'(bus.mem_addr), 64'(h_addr));
        chk("t5_data_hold", 64'(bus.mem_wdata), 64'(h_data));
        chk("t5_addr_val", 64'(h_addr), 64'h400);
        chk("t5_we_hold", 64'(bus.mem_we), 64'hF);
        chk("t5_no_writes", 64'(wr_a.size()), 64'd0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        send(cur[5], 1'b1, 20, 1'b0, ok);
        chk("t5_sixth_acc", 64'(ok), 64'd1);
        wait_done(1'b0);
        check_writes(32'h400);

        // random sequences: plain, address wrap, counter saturation
        for (int s = 0; s < 4; s++) begin
            logic [31:0] b;
            int n;
            b = $urandom;
            n = $urandom_range(3, 6);
            if (s == 2) begin b = 32'hFFFF_FFF9; n = 4; end
            if (s == 3) n = 9;
            cur.delete();
            for (int k = 0; k < n; k++) cur.push_back(rnd_req());
            run_seq(b, 1'b1);
        end

        // 6: reset mid-sequence with words pending
        cur = '{rnd_req(), rnd_req(), rnd_req()};
        bus.mem_ready = 1'b0;
        pulse_start(32'h800);
        for (int k = 0; k < 3; k++) begin
            send(cur[k], 1'b0, 4, 1'b0, ok);
            chk("t6_accept", 64'(ok), 64'd1);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_a.delete(); wr_d.delete();
        @(negedge clk);
        chk("t6_we", 64'(bus.mem_we), 64'd0);
        chk("t6_addr", 64'(bus.mem_addr), 64'd0);
        chk("t6_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("t6_flags", 64'({busy, done, err}), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        @(posedge clk); #1;
        bus.mem_ready = 1'b1;
        send(rnd_req(), 1'b1, 4, 1'b0, ok);
        chk("t6_idle_reject", 64'(ok), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_no_writes", 64'(wr_a.size()), 64'd0);
        chk("t6_idle", 64'({busy, done}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
